// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the async FIFO pointer stages.
//   - DEFAULT_ADDR_WIDTH / DEFAULT_SYNC_STAGES : default build parameters
//   - MAX_PTR_WIDTH                            : widest pointer the helpers support
//   - bin2gray / gray2bin                      : Gray code conversion helpers
//
// The conversion helpers work on MAX_PTR_WIDTH-wide vectors. A PTR_WIDTH-wide
// pointer is zero-extended on the way in and truncated on the way out. Because
// the extension bits are zero, both conversions give the same low PTR_WIDTH
// bits as a native PTR_WIDTH-wide conversion would, so one pair of functions
// serves every pointer width.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 3;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int MAX_PTR_WIDTH       = 32;

  // g = b ^ (b >> 1)
  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(
    input logic [MAX_PTR_WIDTH-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  // Working down from the MSB, b[i] = b[i+1] ^ g[i].
  function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(
    input logic [MAX_PTR_WIDTH-1:0] g
  );
    logic [MAX_PTR_WIDTH-1:0] b;
    b = '0;
    b[MAX_PTR_WIDTH-1] = g[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync_if.sv
// -----------------------------------------------------------------------------
// fifo_ptr_sync_if
//   Bundle of signals between one pointer stage (slave) and its surroundings
//   (master: the access requester, the flag stage and the remote domain).
//
//   Handshake: inc_req acts as "valid" and ~blocked as "ready". An access is
//   accepted (inc_ack=1) exactly on a clk edge where inc_req=1 and blocked=0.
//   A request made while blocked is not accepted and is not held by the
//   pointer stage; the requester decides whether to retry.
//
//   Signals:
//     inc_req     master->slave  access request (write or read enable)
//     blocked     master->slave  full (write side) / empty (read side)
//     remote_gray master->slave  other domain's Gray pointer, asynchronous
//     inc_ack     slave->master  inc_req & ~blocked, combinational
//     ptr_bin     slave->master  local binary pointer, registered
//     ptr_gray    slave->master  local Gray pointer, registered
//     addr        slave->master  RAM address, low bits of ptr_bin
//     remote_bin  slave->master  synchronised remote pointer, binary
//     err         slave->master  sticky reject flag (only with FIFO_PTR_ERR_EN)
// -----------------------------------------------------------------------------
interface fifo_ptr_sync_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int PTR_WIDTH  = ADDR_WIDTH + 1
);

  logic                  inc_req;
  logic                  blocked;
  logic                  inc_ack;
  logic [PTR_WIDTH-1:0]  ptr_bin;
  logic [PTR_WIDTH-1:0]  ptr_gray;
  logic [ADDR_WIDTH-1:0] addr;
  logic [PTR_WIDTH-1:0]  remote_gray;
  logic [PTR_WIDTH-1:0]  remote_bin;
`ifdef FIFO_PTR_ERR_EN
  logic                  err;
`endif

`ifdef FIFO_PTR_ERR_EN
  modport master (
    output inc_req, blocked, remote_gray,
    input  inc_ack, ptr_bin, ptr_gray, addr, remote_bin, err
  );

  modport slave (
    input  inc_req, blocked, remote_gray,
    output inc_ack, ptr_bin, ptr_gray, addr, remote_bin, err
  );
`else
  modport master (
    output inc_req, blocked, remote_gray,
    input  inc_ack, ptr_bin, ptr_gray, addr, remote_bin
  );

  modport slave (
    input  inc_req, blocked, remote_gray,
    output inc_ack, ptr_bin, ptr_gray, addr, remote_bin
  );
`endif

endinterface

// File: rtl/fifo_ptr_sync_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   WIDTH x STAGES flip-flop pipeline for bringing a Gray-coded bus into the
//   local clock domain. The first stage samples d unconditionally; q is the
//   output of the last stage. Synchronous active-high reset clears all stages.
//
//   Only use it for values that change at most one bit between samples
//   (Gray pointers); a plain binary bus would be captured incoherently.
//
//   Ports:
//     clk  in   local clock
//     rst  in   synchronous reset, active-high
//     d    in   WIDTH  asynchronous input
//     q    out  WIDTH  synchronised output, STAGES edges after d
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_ptr_sync.sv
// -----------------------------------------------------------------------------
// fifo_ptr_sync
//   Per-domain pointer stage of the async FIFO. One instance lives in the
//   write domain, one in the read domain.
//   - Holds the local binary pointer and advances it on every accepted access.
//   - Publishes the pointer as registered Gray code (ptr_gray), the only
//     signal that crosses to the other domain.
//   - Resynchronises the remote Gray pointer, converts it to binary and
//     registers it as remote_bin for the flag stage.
//   Write side feeds the flag stage (ptr_bin, remote_bin); read side feeds it
//   (remote_bin, ptr_bin).
//
//   Parameters:
//     ADDR_WIDTH   RAM address width, depth = 2**ADDR_WIDTH
//     PTR_WIDTH    ADDR_WIDTH+1, MSB is the wrap bit
//     SYNC_STAGES  synchroniser depth, 2..4
//
//   Ports:
//     clk   in  local domain clock
//     rst   in  synchronous reset, active-high
//     bus   fifo_ptr_sync_if.slave (inc_req, blocked, remote_gray in;
//           inc_ack, ptr_bin, ptr_gray, addr, remote_bin [, err] out)
//
//   Build option FIFO_PTR_ERR_EN: adds bus.err, a sticky flag set on any edge
//   where a request is made while blocked. Cleared only by rst. Without the
//   macro a rejected request is simply dropped.
// -----------------------------------------------------------------------------
module fifo_ptr_sync
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int PTR_WIDTH   = ADDR_WIDTH + 1,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic           clk,
  input  logic           rst,
  fifo_ptr_sync_if.slave bus
);

  logic                 inc_ack;
  logic [PTR_WIDTH-1:0] ptr_bin_q;
  logic [PTR_WIDTH-1:0] ptr_gray_q;
  logic [PTR_WIDTH-1:0] ptr_next;
  logic [PTR_WIDTH-1:0] ptr_gray_next;
  logic [PTR_WIDTH-1:0] remote_sync;
  logic [PTR_WIDTH-1:0] remote_bin_next;
  logic [PTR_WIDTH-1:0] remote_bin_q;

  // blocked comes combinationally from the flag stage and is used unregistered
  // so a full/empty decision takes effect in the same cycle.
  assign inc_ack = bus.inc_req & ~bus.blocked;

  // Natural overflow of the adder gives the modulo-2**PTR_WIDTH wrap.
  assign ptr_next = ptr_bin_q + PTR_WIDTH'(1);

  // Gray is derived from the next binary value and registered alongside it,
  // so ptr_gray is a clean flop output with no conversion logic behind it.
  assign ptr_gray_next = PTR_WIDTH'(bin2gray(MAX_PTR_WIDTH'(ptr_next)));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
    end else if (inc_ack) begin
      ptr_bin_q  <= ptr_next;
      ptr_gray_q <= ptr_gray_next;
    end
  end

  // Remote pointer path: SYNC_STAGES flops, then a registered conversion.
  // The result lags the remote domain, which only ever makes the flag stage
  // more pessimistic (less free space / less data), never optimistic.
  sync_chain #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_remote_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.remote_gray),
    .q   (remote_sync)
  );

  assign remote_bin_next = PTR_WIDTH'(gray2bin(MAX_PTR_WIDTH'(remote_sync)));

  always_ff @(posedge clk) begin
    if (rst) begin
      remote_bin_q <= '0;
    end else begin
      remote_bin_q <= remote_bin_next;
    end
  end

`ifdef FIFO_PTR_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.inc_req & bus.blocked) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`endif

  assign bus.inc_ack    = inc_ack;
  assign bus.ptr_bin    = ptr_bin_q;
  assign bus.ptr_gray   = ptr_gray_q;
  assign bus.addr       = ptr_bin_q[ADDR_WIDTH-1:0];
  assign bus.remote_bin = remote_bin_q;

endmodule

// File: tb/tb_fifo_ptr_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_ptr_sync
//   Directed bench for fifo_ptr_sync with ADDR_WIDTH=3, SYNC_STAGES=2.
//   A vector table covers reset, wrap, blocked and back-to-back behaviour;
//   hand-written sequences cover remote synchroniser latency and a walk of
//   the remote pointer driven from an unrelated slower clock.
//   Define FIFO_PTR_ERR_EN to also check the sticky err flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_ptr_sync;

  localparam int AW = 3;
  localparam int PW = AW + 1;

  // ---------------------------------------------------------------- clocks
  logic clk  = 1'b0;
  logic rclk = 1'b0;
  logic rst  = 1'b1;

  always #5    clk  = ~clk;   // 10 ns local clock
  always #13.5 rclk = ~rclk;  // 27 ns remote clock, ~0.37x

  // ---------------------------------------------------------------- DUT
  fifo_ptr_sync_if #(.ADDR_WIDTH(AW), .PTR_WIDTH(PW)) bus ();

  fifo_ptr_sync #(
    .ADDR_WIDTH  (AW),
    .PTR_WIDTH   (PW),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------------------------------------------------------- scoreboard
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  // Reference 4-bit Gray codes, written out by hand.
  function automatic logic [3:0] gray4(input logic [3:0] b);
    case (b)
      4'd0:  return 4'b0000;
      4'd1:  return 4'b0001;
      4'd2:  return 4'b0011;
      4'd3:  return 4'b0010;
      4'd4:  return 4'b0110;
      4'd5:  return 4'b0111;
      4'd6:  return 4'b0101;
      4'd7:  return 4'b0100;
      4'd8:  return 4'b1100;
      4'd9:  return 4'b1101;
      4'd10: return 4'b1111;
      4'd11: return 4'b1110;
      4'd12: return 4'b1010;
      4'd13: return 4'b1011;
      4'd14: return 4'b1001;
      default: return 4'b1000;
    endcase
  endfunction

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        rst;
    logic        req;
    logic        blk;
    logic [3:0]  rgray;
    logic [3:0]  exp_bin;
    logic        exp_ack;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  logic err_exp = 1'b0;

  task automatic add(input logic r, input logic q, input logic b,
                     input logic [3:0] rg, input logic [3:0] eb,
                     input logic ea);
    vec_t v;
    if (r)          err_exp = 1'b0;
    else if (q & b) err_exp = 1'b1;
    v.rst = r; v.req = q; v.blk = b; v.rgray = rg;
    v.exp_bin = eb; v.exp_ack = ea; v.exp_err = err_exp;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    // reset dominates inc_req; remote input is nonzero but must not leak
    for (int i = 0; i < 3; i++) add(1, 1, 0, 4'hF, 4'd0, 1);
    // 16 accepted increments: 1..15 then wrap to 0
    for (int i = 0; i < 16; i++) add(0, 1, 0, 4'h0, 4'((i + 1) % 16), 1);
    // climb to 5
    for (int i = 0; i < 5; i++) add(0, 1, 0, 4'h0, 4'(i + 1), 1);
    // blocked requests: pointer holds at 5
    for (int i = 0; i < 4; i++) add(0, 1, 1, 4'h0, 4'd5, 0);
    // blocked without request
    add(0, 0, 1, 4'h0, 4'd5, 0);
    // reset, then 3 increments to 3 and 10 back-to-back to 13
    add(1, 0, 0, 4'h0, 4'd0, 0);
    for (int i = 0; i < 3; i++)  add(0, 1, 0, 4'h0, 4'(i + 1), 1);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 4'h0, 4'(i + 4), 1);
    // idle holds
    add(0, 0, 0, 4'h0, 4'd13, 0);
    // reset mid-operation with a request pending
    add(1, 1, 0, 4'h0, 4'd0, 1);
  endtask

  // ---------------------------------------------------------------- driver
  task automatic apply_vec(input vec_t v, input logic [3:0] prev_gray);
    @(negedge clk);
    rst             = v.rst;
    bus.inc_req     = v.req;
    bus.blocked     = v.blk;
    bus.remote_gray = v.rgray;
    #1;
    check("inc_ack", 32'(bus.inc_ack), 32'(v.exp_ack));
    @(posedge clk);
    #1;
    check("ptr_bin",    32'(bus.ptr_bin),    32'(v.exp_bin));
    check("ptr_gray",   32'(bus.ptr_gray),   32'(gray4(v.exp_bin)));
    check("addr",       32'(bus.addr),       32'(v.exp_bin[2:0]));
    check("remote_bin", 32'(bus.remote_bin), 32'd0);
`ifdef FIFO_PTR_ERR_EN
    check("err",        32'(bus.err),        32'(v.exp_err));
`endif
    if (!v.rst && v.exp_ack) begin
      check("gray_one_bit", 32'($countones(bus.ptr_gray ^ prev_gray)), 32'd1);
    end
  endtask

  // ---------------------------------------------------------------- walk state
  logic [3:0] src_bin;
  logic       src_done;
  logic       mono_ok;
  logic       lag_ok;

  // ---------------------------------------------------------------- main
  initial begin
    logic [3:0] prev_gray;
    logic [3:0] prev_rb;
    logic [3:0] cur_rb;
    int         cyc;

    bus.inc_req     = 1'b1;
    bus.blocked     = 1'b0;
    bus.remote_gray = 4'hF;
    prev_gray       = 4'h0;

    build_table();
    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], prev_gray);
      prev_gray = bus.ptr_gray;
    end

    // ---- sync latency: remote 6 -> 7 (Gray 0101 -> 0100)
    @(negedge clk);
    rst             = 1'b0;
    bus.inc_req     = 1'b0;
    bus.blocked     = 1'b0;
    bus.remote_gray = 4'b0101;
    repeat (5) @(posedge clk);
    #1;
    check("sync_settle_6", 32'(bus.remote_bin), 32'd6);
    @(negedge clk);                       // just after edge N
    bus.remote_gray = 4'b0100;
    @(posedge clk); #1;
    check("sync_n1_still_6", 32'(bus.remote_bin), 32'd6);
    @(posedge clk); #1;
    check("sync_n2_still_6", 32'(bus.remote_bin), 32'd6);
    @(posedge clk); #1;
    check("sync_n3_now_7", 32'(bus.remote_bin), 32'd7);

    // ---- async walk: 100 remote increments from a 27 ns clock
    src_bin  = 4'd7;
    src_done = 1'b0;
    mono_ok  = 1'b1;
    lag_ok   = 1'b1;
    prev_rb  = bus.remote_bin;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(posedge rclk);
          src_bin         = src_bin + 4'd1;
          bus.remote_gray = gray4(src_bin);
        end
        src_done = 1'b1;
      end
      begin
        cyc = 0;
        while (!src_done && cyc < 2000) begin
          @(negedge clk);
          cur_rb = bus.remote_bin;
          if (4'(cur_rb - prev_rb) > 4'd1) mono_ok = 1'b0;
          if (4'(src_bin - cur_rb) > 4'd3) lag_ok = 1'b0;
          prev_rb = cur_rb;
          cyc++;
        end
      end
    join
    check("walk_src_finished", 32'(src_done), 32'd1);
    check("walk_monotonic",    32'(mono_ok),  32'd1);
    check("walk_never_ahead",  32'(lag_ok),   32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("walk_converged", 32'(bus.remote_bin), 32'd11);  // 7 + 100 mod 16

    // ---- reset clears remote_bin and pointer together
    @(negedge clk);
    rst         = 1'b1;
    bus.inc_req = 1'b1;
    @(posedge clk); #1;
    check("final_reset_remote", 32'(bus.remote_bin), 32'd0);
    check("final_reset_ptr",    32'(bus.ptr_bin),    32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "timeout");
  end

endmodule
